// File: rtl/tt_mux_pkg.sv
// Shared definitions for the tile project-select controller.
// Holds the controller state encoding, the default slot geometry, the bit
// positions inside a slot's 18-bit input word, and a helper that sizes the
// shared phase counter.
package tt_mux_pkg;

  localparam int unsigned NPROJ  = 20;  // project slots
  localparam int unsigned ADDR_W = 5;   // select address width
  localparam int unsigned OW_W   = 24;  // {uio_oe, uio_out, uo_out}
  localparam int unsigned IW_W   = 18;  // {uio_in, ui_in, rst_n, clk}

  // Slot input-word bit positions.
  localparam int unsigned IW_CLK    = 0;
  localparam int unsigned IW_RST_N  = 1;
  localparam int unsigned IW_UI_LO  = 2;
  localparam int unsigned IW_UI_HI  = 9;
  localparam int unsigned IW_UIO_LO = 10;
  localparam int unsigned IW_UIO_HI = 17;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDisable = 2'd1,
    StReset   = 2'd2,
    StRun     = 2'd3
  } state_e;

  // Width of a down-counter that must hold the longer of the two phases.
  function automatic int unsigned cnt_width(int unsigned guard, int unsigned rst_len);
    int unsigned mx;
    mx = (guard > rst_len) ? guard : rst_len;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/tt_proj_sel_ctrl_if.sv
// Host-side select bundle of the project-select controller.
//   sel_valid/sel_ready : request handshake (transfer on valid && ready)
//   sel_addr, sel_off   : requested slot / deselect-all flag
//   sel_err             : one-cycle pulse when an out-of-range slot is rejected
//   active, active_addr : running flag and the slot being (or already) enabled
// master = host/config logic, slave = controller.
interface tt_proj_sel_ctrl_if #(
  parameter int unsigned ADDR_W = 5
) ();

  logic              sel_valid;
  logic              sel_ready;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_off;
  logic              sel_err;
  logic              active;
  logic [ADDR_W-1:0] active_addr;

  modport master (
    output sel_valid, sel_addr, sel_off,
    input  sel_ready, sel_err, active, active_addr
  );

  modport slave (
    input  sel_valid, sel_addr, sel_off,
    output sel_ready, sel_err, active, active_addr
  );

endinterface

// File: rtl/tt_ow_mux.sv
// Registered NPROJ:1 selector for slot output words.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   run_i        : selected slot stays in RUN across this edge
//   addr_i       : selected slot index
//   ow_all_i     : concatenated slot words, slot i at [i*OW_W +: OW_W]
//   ow_sel_o     : registered word of the selected slot, zero when not running
module tt_ow_mux #(
  parameter int unsigned NPROJ  = 20,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OW_W   = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [NPROJ*OW_W-1:0] ow_all_i,
  output logic [OW_W-1:0]       ow_sel_o
);

  logic [OW_W-1:0] ow_d, ow_q;

  // Compare-and-select loop keeps every part-select in range for any addr_i.
  always_comb begin
    ow_d = '0;
    for (int unsigned i = 0; i < NPROJ; i++) begin
      if (run_i && (addr_i == ADDR_W'(i))) begin
        ow_d = ow_all_i[i*OW_W +: OW_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ow_q <= '0;
    end else begin
      ow_q <= ow_d;
    end
  end

  assign ow_sel_o = ow_q;

endmodule

// File: rtl/tt_proj_sel_ctrl.sv
// Project-select controller: shares the tile I/O bundle among NPROJ slots.
// A select runs DISABLE (all enables off for GUARD_CYCLES) -> RESET (chosen
// slot enabled, proj_rst_n low for RST_CYCLES) -> RUN. A deselect runs
// DISABLE -> IDLE. All outputs are registered.
//   clk, rst   : clock, asynchronous active-high reset
//   sel        : host select bundle (slave side)
//   ena        : one-hot-or-zero slot enables
//   proj_rst_n : active-low reset to the enabled slot
//   ow_all     : concatenated slot output words
//   ow_sel     : registered output word of the running slot
module tt_proj_sel_ctrl #(
  parameter int unsigned NPROJ        = tt_mux_pkg::NPROJ,
  parameter int unsigned ADDR_W       = tt_mux_pkg::ADDR_W,
  parameter int unsigned OW_W         = tt_mux_pkg::OW_W,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned RST_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_proj_sel_ctrl_if.slave     sel,
  output logic [NPROJ-1:0]      ena,
  output logic                  proj_rst_n,
  input  logic [NPROJ*OW_W-1:0] ow_all,
  output logic [OW_W-1:0]       ow_sel
);

  import tt_mux_pkg::*;

  localparam int unsigned     CntW      = cnt_width(GUARD_CYCLES, RST_CYCLES);
  // Counter is loaded with length-1 on entry and leaves the phase at zero.
  localparam logic [CntW-1:0] GuardLoad = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] RstLoad   = CntW'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              off_q, off_d;      // current DISABLE ends in IDLE
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NPROJ-1:0]  ena_q, ena_d;
  logic              prst_n_q, prst_n_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic xfer;
  logic addr_ok;

  assign xfer    = sel.sel_valid && ready_q;
  assign addr_ok = 32'(sel.sel_addr) < NPROJ;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      off_q    <= 1'b0;
      addr_q   <= '0;
      ena_q    <= '0;
      prst_n_q <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      ena_q    <= ena_d;
      prst_n_q <= prst_n_d;
      active_q <= active_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    addr_d  = addr_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (xfer) begin
          if (sel.sel_off) begin
            // Deselect from IDLE has nothing to tear down.
            if (state_q == StRun) begin
              state_d = StDisable;
              cnt_d   = GuardLoad;
              off_d   = 1'b1;
            end
          end else if (!addr_ok) begin
            err_d = 1'b1;
          end else begin
            state_d = StDisable;
            cnt_d   = GuardLoad;
            off_d   = 1'b0;
            addr_d  = sel.sel_addr;
          end
        end
      end
      StDisable: begin
        if (cnt_q == '0) begin
          if (off_q) begin
            state_d = StIdle;
          end else begin
            state_d = StReset;
            cnt_d   = RstLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReset: begin
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: registered outputs follow the next state.
  always_comb begin
    ready_d  = (state_d == StIdle) || (state_d == StRun);
    prst_n_d = (state_d == StRun);
    active_d = (state_d == StRun);
    for (int unsigned i = 0; i < NPROJ; i++) begin
      ena_d[i] = ((state_d == StReset) || (state_d == StRun)) && (addr_d == ADDR_W'(i));
    end
  end

  // Word is passed only while the slot stays in RUN, so a restart or
  // deselect zeroes it on the following cycle.
  tt_ow_mux #(
    .NPROJ  (NPROJ),
    .ADDR_W (ADDR_W),
    .OW_W   (OW_W)
  ) u_ow_mux (
    .clk_i    (clk),
    .rst_i    (rst),
    .run_i    ((state_q == StRun) && (state_d == StRun)),
    .addr_i   (addr_q),
    .ow_all_i (ow_all),
    .ow_sel_o (ow_sel)
  );

  assign ena             = ena_q;
  assign proj_rst_n      = prst_n_q;
  assign sel.sel_ready   = ready_q;
  assign sel.sel_err     = err_q;
  assign sel.active      = active_q;
  assign sel.active_addr = addr_q;

endmodule
